// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the two-port BRAM arbiter: grant encoding, widths and defaults.
package bram_arbiter_pkg;

  localparam int unsigned DEPTH_DEF  = 8192;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned WR_ADDR_W  = 13;
  localparam int unsigned RD_ADDR_W  = 20;
  localparam int unsigned BRAM_WA_W  = 32;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned GNT_W      = 2;
  localparam int unsigned GNT_BIT_WR = 0;
  localparam int unsigned GNT_BIT_RD = 1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// Two-requester round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
  import bram_arbiter_pkg::*;
(
  input  logic             req_wr,
  input  logic             req_rd,
  input  gnt_e             last_gnt,
  output logic [GNT_W-1:0] gnt_c
);

  always_comb begin
    gnt_c = '0;
    if (req_wr && req_rd) begin
      if (last_gnt == GNT_WR) gnt_c[GNT_BIT_RD] = 1'b1;
      else                    gnt_c[GNT_BIT_WR] = 1'b1;
    end else if (req_wr) begin
      gnt_c[GNT_BIT_WR] = 1'b1;
    end else if (req_rd) begin
      gnt_c[GNT_BIT_RD] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between a write requester and a read requester with
// round-robin arbitration, one-cycle read responses and a saturating conflict counter.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WR_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic                 bram_wr_rd_en,
  output logic [BRAM_WA_W-1:0] bram_wr_addr,
  output logic [RD_ADDR_W-1:0] bram_rd_addr,
  output logic [DATA_W-1:0]    bram_data_in,
  input  logic [DATA_W-1:0]    bram_data_out,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic [GNT_W-1:0]     gnt_c;
  logic                 wr_gnt_c;
  logic                 rd_gnt_c;
  logic                 wr_in_range_c;
  logic                 rd_bad_c;
  gnt_e                 last_grant;
  logic [RD_ADDR_W-1:0] rd_addr_q;
  logic                 rsp_pend_q;
  logic                 rsp_err_q;

  rr_arb2 u_arb (
    .req_wr   (wr_valid),
    .req_rd   (rd_valid),
    .last_gnt (last_grant),
    .gnt_c    (gnt_c)
  );

  // Grants are suppressed while reset is held so nothing reaches the BRAM.
  assign wr_gnt_c      = gnt_c[GNT_BIT_WR] & rst_n;
  assign rd_gnt_c      = gnt_c[GNT_BIT_RD] & rst_n;
  assign wr_ready      = wr_gnt_c;
  assign rd_ready      = rd_gnt_c;

  assign wr_in_range_c = 32'(wr_addr) < DEPTH;
  assign rd_bad_c      = (rd_addr[1:0] != 2'b00) || (32'(rd_addr[RD_ADDR_W-1:2]) >= DEPTH);

  assign bram_wr_rd_en = wr_gnt_c & wr_in_range_c;
  assign bram_wr_addr  = BRAM_WA_W'(wr_addr);
  assign bram_data_in  = wr_data;
  assign bram_rd_addr  = rd_gnt_c ? rd_addr : rd_addr_q;

  // A pending response is masked during reset so a read granted just before reset never surfaces.
  assign rsp_valid     = rsp_pend_q & rst_n;
  assign rsp_err       = rsp_valid & rsp_err_q;
  assign rsp_data      = (rsp_valid && !rsp_err_q) ? bram_data_out : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant   <= GNT_RD;
      rd_addr_q    <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (wr_gnt_c)      last_grant <= GNT_WR;
      else if (rd_gnt_c) last_grant <= GNT_RD;
      if (rd_gnt_c) rd_addr_q <= rd_addr;
      rsp_pend_q <= rd_gnt_c;
      rsp_err_q  <= rd_gnt_c & rd_bad_c;
      if (wr_valid && rd_valid && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural BRAM that registers read data.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready;
  logic [12:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [19:0] rd_addr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        bram_wr_rd_en;
  logic [31:0] bram_wr_addr;
  logic [19:0] bram_rd_addr;
  logic [31:0] bram_data_in;
  logic [31:0] bram_data_out;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [int];

  always #5 clk = ~clk;

  bram_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .bram_wr_rd_en (bram_wr_rd_en),
    .bram_wr_addr  (bram_wr_addr),
    .bram_rd_addr  (bram_rd_addr),
    .bram_data_in  (bram_data_in),
    .bram_data_out (bram_data_out),
    .conflict_cnt  (conflict_cnt)
  );

  // Single-port BRAM: write when enabled, otherwise read the word at byte address / 4.
  always @(posedge clk) begin
    if (bram_wr_rd_en) begin
      mem[int'(bram_wr_addr[12:0])] = bram_data_in;
    end else begin
      bram_data_out <= mem.exists(int'(bram_rd_addr[14:2])) ? mem[int'(bram_rd_addr[14:2])] : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 13'd100; wr_data = 32'hA5A50001; rd_addr = 20'd400;
    tick(); tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_rd_addr", bram_rd_addr, 0);
    chk("rst_wr_en", bram_wr_rd_en, 0);

    // Continuous conflict from reset: W,R,W,R,W,R
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("cf%0d_wr_ready", i), wr_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cf%0d_rd_ready", i), rd_ready, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("cf%0d_wr_en", i), bram_wr_rd_en, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cf%0d_rsp_valid", i), rsp_valid, (i >= 2 && i % 2 == 0) ? 1 : 0);
      if (i >= 2 && i % 2 == 0) chk($sformatf("cf%0d_rsp_data", i), rsp_data, 32'hA5A50001);
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; #1;
    chk("cf_cnt6", conflict_cnt, 6);
    chk("cf_last_rsp_valid", rsp_valid, 1);
    chk("cf_last_rsp_data", rsp_data, 32'hA5A50001);
    chk("cf_last_rsp_err", rsp_err, 0);
    chk("idle_wr_ready", wr_ready, 0);
    chk("idle_rd_ready", rd_ready, 0);
    chk("idle_rd_addr_held", bram_rd_addr, 400);

    // Write addr 5 then read byte address 20
    tick();
    chk("idle_no_rsp", rsp_valid, 0);
    wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 32'hDEADBEEF; #1;
    chk("w5_ready", wr_ready, 1);
    chk("w5_en", bram_wr_rd_en, 1);
    chk("w5_addr", bram_wr_addr, 5);
    chk("w5_data", bram_data_in, 32'hDEADBEEF);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 20'd20; #1;
    chk("r20_ready", rd_ready, 1);
    chk("r20_en", bram_wr_rd_en, 0);
    chk("r20_addr", bram_rd_addr, 20);
    tick();
    rd_valid = 1'b0; #1;
    chk("r20_rsp_valid", rsp_valid, 1);
    chk("r20_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("r20_rsp_err", rsp_err, 0);
    tick();
    chk("r20_rsp_once", rsp_valid, 0);

    // Back-to-back write addr 3 then read byte address 12
    wr_valid = 1'b1; wr_addr = 13'd3; wr_data = 32'h12345678; #1;
    chk("w3_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 20'd12; #1;
    chk("r12_ready", rd_ready, 1);
    tick();
    rd_valid = 1'b0; #1;
    chk("r12_rsp_valid", rsp_valid, 1);
    chk("r12_rsp_data", rsp_data, 32'h12345678);

    // last_grant holds through an idle cycle: write, idle, conflict -> read wins
    tick();
    wr_valid = 1'b1; wr_addr = 13'd7; wr_data = 32'h0BADF00D; #1;
    chk("rr_w_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0; #1;
    tick();
    wr_valid = 1'b1; rd_valid = 1'b1; rd_addr = 20'd28; #1;
    chk("rr_conf_rd_ready", rd_ready, 1);
    chk("rr_conf_wr_ready", wr_ready, 0);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0; #1;
    chk("rr_rsp_data", rsp_data, 32'h0BADF00D);
    chk("rr_cnt7", conflict_cnt, 7);

    // Misaligned reads: granted, answered with error and zero data
    tick();
    rd_valid = 1'b1; rd_addr = 20'h00007; #1;
    chk("mis7_ready", rd_ready, 1);
    tick();
    rd_addr = 20'h00015; #1;
    chk("mis7_rsp_valid", rsp_valid, 1);
    chk("mis7_rsp_err", rsp_err, 1);
    chk("mis7_rsp_data", rsp_data, 0);
    tick();
    rd_valid = 1'b0; #1;
    chk("mis15_rsp_err", rsp_err, 1);
    chk("mis15_rsp_data", rsp_data, 0);
    tick();
    chk("mis_rsp_err_clear", rsp_err, 0);

    // Range edge: last word writable, one past it errors
    wr_valid = 1'b1; wr_addr = 13'd8191; wr_data = 32'hCAFEF00D; #1;
    chk("w8191_ready", wr_ready, 1);
    chk("w8191_en", bram_wr_rd_en, 1);
    chk("w8191_addr", bram_wr_addr, 8191);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 20'd32768; #1;
    chk("r32768_ready", rd_ready, 1);
    tick();
    rd_addr = 20'd32764; #1;
    chk("r32768_rsp_err", rsp_err, 1);
    chk("r32768_rsp_data", rsp_data, 0);
    tick();
    rd_valid = 1'b0; #1;
    chk("r32764_rsp_err", rsp_err, 0);
    chk("r32764_rsp_data", rsp_data, 32'hCAFEF00D);
    tick();

    // Reset right after a read grant: no response survives
    rd_valid = 1'b1; rd_addr = 20'd20; #1;
    chk("rmid_ready", rd_ready, 1);
    tick();
    rst_n = 1'b0; wr_valid = 1'b1; #1;
    chk("rmid_rsp_valid_in_rst", rsp_valid, 0);
    chk("rmid_rd_ready_in_rst", rd_ready, 0);
    chk("rmid_wr_ready_in_rst", wr_ready, 0);
    tick();
    rst_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; #1;
    chk("rmid_rsp_valid_after", rsp_valid, 0);
    chk("rmid_cnt", conflict_cnt, 0);
    chk("rmid_rd_addr", bram_rd_addr, 0);
    tick();
    chk("rmid_rsp_valid_later", rsp_valid, 0);

    // First conflict after reset goes to the writer again
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 13'd9; #1;
    chk("post_rst_wr_first", wr_ready, 1);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0; #1;
    chk("post_rst_cnt1", conflict_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
